phy_burst_engine: RTL
=====================

PHY_BURST_ENGINE -- requirements
Module: phy_burst_engine

Interface
REQ-001 Parameter DQ_W, default 16, DQ beat width in bits.
REQ-002 Parameter BL, default 8, beats per burst; fixed at 8.
REQ-003 Parameter WL, default 4, write latency in cycles, legal range 1..15.
REQ-004 Parameter RL, default 6, read latency in cycles, legal range 1..15.
REQ-005 Parameter RD_TIMEOUT, default 16, maximum idle cycles between read beats.
REQ-006 clk1  in  1  single clock; all logic rising-edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 i_cmd_valid  in  1  command present.
REQ-009 o_cmd_ready  out  1  engine can accept a command.
REQ-010 i_cmd  in  bank_command_t  command code; CMD_WRITE and CMD_READ move data.
REQ-011 i_bank_address  in  BA_BITS  bank of the command.
REQ-012 i_full_write_data  in  BL*DQ_W  write burst, sampled at acceptance.
REQ-013 dq_out  out  DQ_W  write beat to the pad.
REQ-014 dq_oe  out  1  dq_out drive enable.
REQ-015 dq_in  in  DQ_W  read beat from the pad.
REQ-016 dq_in_valid  in  1  dq_in holds a valid beat.
REQ-017 o_full_read_data  out  BL*DQ_W  assembled read burst.
REQ-018 o_read_data_valid  out  1  one-cycle pulse; o_full_read_data valid.
REQ-019 o_rd_timeout  out  1  one-cycle pulse; read burst aborted.
REQ-020 o_busy_bank  out  BA_BITS  bank of the burst in flight.

Function
REQ-021 A command SHALL be accepted in a cycle T in which i_cmd_valid and o_cmd_ready are both high.
REQ-022 o_cmd_ready SHALL be high only in state IDLE.
REQ-023 FSM states SHALL be IDLE, WR_WAIT, WR_BURST, RD_WAIT, RD_CAPTURE.
REQ-024 Commands other than read/write SHALL be accepted and dropped; the FSM SHALL stay in IDLE.
REQ-025 On write acceptance, the engine SHALL latch i_full_write_data and i_bank_address, load the latency counter with WL-1, and enter WR_WAIT.
REQ-026 Beat k (bits [k*DQ_W +: DQ_W]) SHALL appear on dq_out, with dq_oe high, in cycle T+WL+k for k=0..7.
REQ-027 dq_oe SHALL be low and dq_out zero in every other cycle.
REQ-028 After beat 7, the FSM SHALL return to IDLE, with o_cmd_ready high in cycle T+WL+8.
REQ-029 On read acceptance, the engine SHALL wait RL cycles in RD_WAIT, then enter RD_CAPTURE in cycle T+RL.
REQ-030 In RD_CAPTURE, each cycle with dq_in_valid high SHALL store dq_in into beat slot n (LSB first) and increment beat count n (3 bits).
REQ-031 The cycle after the 8th beat is stored, o_full_read_data SHALL update, o_read_data_valid SHALL pulse once, and the FSM SHALL enter IDLE.
REQ-032 o_full_read_data SHALL hold its value until the next completed read.
REQ-033 dq_in_valid outside RD_CAPTURE SHALL be ignored.
REQ-034 An idle counter in RD_CAPTURE SHALL clear on every valid beat.
REQ-035 If the idle counter reaches RD_TIMEOUT, o_rd_timeout SHALL pulse once, the partial burst SHALL be discarded with o_full_read_data unchanged, and the FSM SHALL enter IDLE.
REQ-036 o_busy_bank SHALL hold the latched bank while not in IDLE, and zero in IDLE.

Reset
REQ-037 rst high SHALL immediately force: FSM to IDLE; counters and beat slots to 0; dq_oe, o_read_data_valid, o_rd_timeout to 0; dq_out, o_full_read_data, o_busy_bank to 0.
REQ-038 Reset mid-burst SHALL abort the burst, emit no pulses, and give o_cmd_ready high in the first cycle after rst falls.

Structure
REQ-039 bank_command_t, CMD_READ/CMD_WRITE codes, and the FSM state enum SHALL live in the shared command-definition package.
REQ-040 BA_BITS and DQ_BITS SHALL come from the shared define file.
REQ-041 The only sub-module SHALL be burst_shifter: an 8-beat parallel-load/serial-out and serial-in/parallel-out register.

Verification
REQ-042 Write, WL=4, data 0x7777_6666_5555_4444_3333_2222_1111_0000 at T=10 -> dq_out 0x0000..0x7777 in cycles 14..21, dq_oe high exactly there, ready in cycle 22.
REQ-043 Read, RL=6 at T=10, dq_in_valid on cycles 16..23 with beats 0xA0..0xA7 -> o_read_data_valid pulse at 24 with data 0x00A7_..._00A0.
REQ-044 Read with valid gaps (beats on 16,18,19,25,26,27,28,30) -> correct assembly, single pulse at 31.
REQ-045 Read with valid stalled after beat 3 -> o_rd_timeout pulse 16 cycles after the last beat, previous o_full_read_data retained.
REQ-046 rst asserted during WR_BURST beat 3 -> dq_oe low immediately, no further beats, ready after release.
REQ-047 Back-to-back PRECHARGE, WRITE, READ with i_cmd_valid held -> PRECHARGE taken in 1 cycle, WRITE next cycle, READ accepted only after write completes.

Source files
------------

// File: rtl/phy_burst_engine_pkg.sv
// Shared command definitions for the burst engine: bus widths, bank command
// codes and the engine FSM state encoding.
package phy_burst_engine_pkg;

  localparam int unsigned BA_BITS   = 3;
  localparam int unsigned DQ_BITS   = 16;
  localparam int unsigned BURST_LEN = 8;

  typedef enum logic [2:0] {
    CMD_NOP       = 3'd0,
    CMD_ACTIVATE  = 3'd1,
    CMD_READ      = 3'd2,
    CMD_WRITE     = 3'd3,
    CMD_PRECHARGE = 3'd4,
    CMD_REFRESH   = 3'd5
  } bank_command_t;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WR_WAIT    = 3'd1,
    WR_BURST   = 3'd2,
    RD_WAIT    = 3'd3,
    RD_CAPTURE = 3'd4
  } state_t;

endpackage

// File: rtl/phy_burst_engine_if.sv
// Command, pad and read-result bundle of the burst engine.
//   master : command issuer / pad model (drives i_*, dq_in, dq_in_valid)
//   slave  : the engine (drives o_*, dq_out, dq_oe)
interface phy_burst_engine_if
  import phy_burst_engine_pkg::*;
#(
  parameter int unsigned DQ_W = DQ_BITS,
  parameter int unsigned BL   = BURST_LEN
);
  logic                 i_cmd_valid;
  logic                 o_cmd_ready;
  bank_command_t        i_cmd;
  logic [BA_BITS-1:0]   i_bank_address;
  logic [BL*DQ_W-1:0]   i_full_write_data;
  logic [DQ_W-1:0]      dq_out;
  logic                 dq_oe;
  logic [DQ_W-1:0]      dq_in;
  logic                 dq_in_valid;
  logic [BL*DQ_W-1:0]   o_full_read_data;
  logic                 o_read_data_valid;
  logic                 o_rd_timeout;
  logic [BA_BITS-1:0]   o_busy_bank;

  modport master (
    output i_cmd_valid, i_cmd, i_bank_address, i_full_write_data, dq_in, dq_in_valid,
    input  o_cmd_ready, dq_out, dq_oe, o_full_read_data, o_read_data_valid,
           o_rd_timeout, o_busy_bank
  );

  modport slave (
    input  i_cmd_valid, i_cmd, i_bank_address, i_full_write_data, dq_in, dq_in_valid,
    output o_cmd_ready, dq_out, dq_oe, o_full_read_data, o_read_data_valid,
           o_rd_timeout, o_busy_bank
  );
endinterface

// File: rtl/phy_burst_engine_burst_shifter.sv
// burst_shifter: BL-beat register, parallel-load/serial-out (LSB beat first)
// for writes and serial-in/parallel-out (first beat ends at LSB) for reads.
//   load/load_data : parallel load (highest priority)
//   shift_out      : drop the LSB beat; sout is the current LSB beat
//   shift_in/sin   : insert sin at the MSB beat slot; par_hi is beats 1..BL-1
module burst_shifter #(
  parameter int unsigned DQ_W = 16,
  parameter int unsigned BL   = 8
) (
  input  logic                   clk1,
  input  logic                   rst,
  input  logic                   load,
  input  logic [BL*DQ_W-1:0]     load_data,
  input  logic                   shift_out,
  input  logic                   shift_in,
  input  logic [DQ_W-1:0]        sin,
  output logic [DQ_W-1:0]        sout,
  output logic [(BL-1)*DQ_W-1:0] par_hi
);
  localparam int unsigned BUS_W = BL * DQ_W;

  logic [BUS_W-1:0] data_q, data_d;

  // next-value select
  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = load_data;
    end else if (shift_out) begin
      data_d = {{DQ_W{1'b0}}, data_q[BUS_W-1:DQ_W]};
    end else if (shift_in) begin
      data_d = {sin, data_q[BUS_W-1:DQ_W]};
    end
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) data_q <= '0;
    else     data_q <= data_d;
  end

  assign sout   = data_q[DQ_W-1:0];
  assign par_hi = data_q[BUS_W-1:DQ_W];
endmodule

// File: rtl/phy_burst_engine.sv
// phy_burst_engine: accepts one bank command at a time; WRITE serialises a
// BL-beat burst onto dq_out WL cycles after acceptance, READ collects BL
// valid beats from dq_in starting RL cycles after acceptance, with an
// inter-beat idle timeout.
//   clk1, rst : clock, async active-high reset
//   bus       : phy_burst_engine_if.slave (command, pad and read result)
module phy_burst_engine
  import phy_burst_engine_pkg::*;
#(
  parameter int unsigned DQ_W       = DQ_BITS,
  parameter int unsigned BL         = BURST_LEN,
  parameter int unsigned WL         = 4,
  parameter int unsigned RL         = 6,
  parameter int unsigned RD_TIMEOUT = 16
) (
  input  logic               clk1,
  input  logic               rst,
  phy_burst_engine_if.slave  bus
);
  localparam int unsigned BUS_W  = BL * DQ_W;
  localparam int unsigned LAT_W  = 4;
  localparam int unsigned IDLE_W = $clog2(RD_TIMEOUT + 1);

  state_t              state_q, state_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic [2:0]          beat_q, beat_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic [BA_BITS-1:0]  bank_q, bank_d;
  logic [DQ_W-1:0]     dq_out_q, dq_out_d;
  logic                dq_oe_q, dq_oe_d;
  logic [BUS_W-1:0]    rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic                rd_to_q, rd_to_d;
  logic                ready_q, ready_d;

  logic                    sh_load, sh_shift_out, sh_shift_in;
  logic [BUS_W-1:0]        sh_load_data;
  logic [DQ_W-1:0]         sh_sout;
  logic [(BL-1)*DQ_W-1:0]  sh_par_hi;
  logic                    accept;

  assign accept = bus.i_cmd_valid & ready_q;

  burst_shifter #(.DQ_W(DQ_W), .BL(BL)) u_shifter (
    .clk1      (clk1),
    .rst       (rst),
    .load      (sh_load),
    .load_data (sh_load_data),
    .shift_out (sh_shift_out),
    .shift_in  (sh_shift_in),
    .sin       (bus.dq_in),
    .sout      (sh_sout),
    .par_hi    (sh_par_hi)
  );

  // next state, counters and registered outputs
  always_comb begin
    state_d      = state_q;
    lat_d        = lat_q;
    beat_d       = beat_q;
    idle_d       = idle_q;
    bank_d       = bank_q;
    dq_out_d     = '0;
    dq_oe_d      = 1'b0;
    rd_data_d    = rd_data_q;
    rd_valid_d   = 1'b0;
    rd_to_d      = 1'b0;
    sh_load      = 1'b0;
    sh_load_data = bus.i_full_write_data;
    sh_shift_out = 1'b0;
    sh_shift_in  = 1'b0;

    case (state_q)
      IDLE: begin
        beat_d = '0;
        idle_d = '0;
        bank_d = '0;
        if (accept && bus.i_cmd == CMD_WRITE) begin
          bank_d  = bus.i_bank_address;
          sh_load = 1'b1;
          if (WL == 1) begin
            // beat 0 goes straight to the pad; the shifter keeps beats 1..7
            dq_out_d     = bus.i_full_write_data[DQ_W-1:0];
            dq_oe_d      = 1'b1;
            sh_load_data = bus.i_full_write_data >> DQ_W;
            state_d      = WR_BURST;
          end else begin
            lat_d   = LAT_W'(WL - 1);
            state_d = WR_WAIT;
          end
        end else if (accept && bus.i_cmd == CMD_READ) begin
          bank_d = bus.i_bank_address;
          if (RL == 1) begin
            state_d = RD_CAPTURE;
          end else begin
            lat_d   = LAT_W'(RL - 1);
            state_d = RD_WAIT;
          end
        end
      end

      WR_WAIT: begin
        // lat_q == 1 is the cycle before beat 0 must be on the pad
        if (lat_q == LAT_W'(1)) begin
          dq_out_d     = sh_sout;
          dq_oe_d      = 1'b1;
          sh_shift_out = 1'b1;
          state_d      = WR_BURST;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end

      WR_BURST: begin
        // beat_q is the index of the beat currently on dq_out
        if (beat_q == 3'd7) begin
          bank_d  = '0;
          state_d = IDLE;
        end else begin
          dq_out_d     = sh_sout;
          dq_oe_d      = 1'b1;
          sh_shift_out = 1'b1;
          beat_d       = beat_q + 3'd1;
        end
      end

      RD_WAIT: begin
        if (lat_q == LAT_W'(1)) state_d = RD_CAPTURE;
        else                    lat_d   = lat_q - LAT_W'(1);
      end

      RD_CAPTURE: begin
        if (bus.dq_in_valid) begin
          sh_shift_in = 1'b1;
          idle_d      = '0;
          if (beat_q == 3'd7) begin
            rd_data_d  = {bus.dq_in, sh_par_hi};
            rd_valid_d = 1'b1;
            bank_d     = '0;
            state_d    = IDLE;
          end else begin
            beat_d = beat_q + 3'd1;
          end
        end else if (idle_q == IDLE_W'(RD_TIMEOUT - 2)) begin
          // registered pulse lands in the RD_TIMEOUT-th idle cycle
          rd_to_d = 1'b1;
          bank_d  = '0;
          state_d = IDLE;
        end else begin
          idle_d = idle_q + IDLE_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      lat_q      <= '0;
      beat_q     <= '0;
      idle_q     <= '0;
      bank_q     <= '0;
      dq_out_q   <= '0;
      dq_oe_q    <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_to_q    <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      lat_q      <= lat_d;
      beat_q     <= beat_d;
      idle_q     <= idle_d;
      bank_q     <= bank_d;
      dq_out_q   <= dq_out_d;
      dq_oe_q    <= dq_oe_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_to_q    <= rd_to_d;
      ready_q    <= ready_d;
    end
  end

  assign bus.o_cmd_ready       = ready_q;
  assign bus.dq_out            = dq_out_q;
  assign bus.dq_oe             = dq_oe_q;
  assign bus.o_full_read_data  = rd_data_q;
  assign bus.o_read_data_valid = rd_valid_q;
  assign bus.o_rd_timeout      = rd_to_q;
  assign bus.o_busy_bank       = bank_q;
endmodule
